// File: rtl/pc_unit_if.sv
// -----------------------------------------------------------------------------
// pc_unit_if
// Request/response bundle between the control unit and the program-counter
// unit.
//   stall, redirect, call, ret : requests issued by the control unit
//   target                     : branch/jump/call destination
//   pc                         : current fetch address (registered)
//   ras_count                  : number of valid return-address stack entries
//   ret_err                    : one-cycle pulse, ret issued with an empty stack
//   align_err                  : one-cycle pulse, misaligned target rejected
// Modports: master = control-unit side, slave = pc_unit side.
// -----------------------------------------------------------------------------
interface pc_unit_if #(
   parameter int WIDTH     = 32,
   parameter int RAS_DEPTH = 4
);
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);

   logic             stall;
   logic             redirect;
   logic             call;
   logic             ret;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] pc;
   logic [CNT_W-1:0] ras_count;
   logic             ret_err;
   logic             align_err;

   modport master (
      output stall, redirect, call, ret, target,
      input  pc, ras_count, ret_err, align_err
   );

   modport slave (
      input  stall, redirect, call, ret, target,
      output pc, ras_count, ret_err, align_err
   );
endinterface

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
// Program-counter unit. Holds the fetch address, advances it by STEP or
// redirects it to a target, and keeps a circular return-address stack so
// call/return pairs redirect without a register-file read.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high
//   bus   : pc_unit_if.slave (requests in, pc/ras_count/error pulses out)
// Action priority per edge: reset > stall > ret > call > redirect > increment.
// Optional feature: define PC_ALIGN_CHECK_EN to reject redirect/call targets
// whose low log2(STEP) bits are non-zero (pc increments, align_err pulses).
// -----------------------------------------------------------------------------
module pc_unit #(
   parameter int               WIDTH     = 32,
   parameter int               STEP      = 4,
   parameter logic [WIDTH-1:0] RESET_VEC = '0,
   parameter int               RAS_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   pc_unit_if.slave    bus
);
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);
   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PTR_W-1:0] top_q, top_d;          // next free slot (oldest slot when full)
   logic             ret_err_q, ret_err_d;
   logic             align_err_q, align_err_d;
   logic [WIDTH-1:0] ras_q [RAS_DEPTH];

   logic [WIDTH-1:0] pc_inc;
   logic [PTR_W-1:0] top_inc, top_dec;
   logic             misaligned;
   logic             push;

   assign pc_inc  = pc_q + WIDTH'(STEP);
   assign top_inc = (top_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : top_q + PTR_W'(1);
   assign top_dec = (top_q == '0) ? PTR_W'(RAS_DEPTH - 1) : top_q - PTR_W'(1);

`ifdef PC_ALIGN_CHECK_EN
   // STEP is a power of two, so STEP-1 masks exactly the low log2(STEP) bits;
   // with STEP=1 the mask is zero and nothing is ever misaligned.
   assign misaligned = (bus.target & WIDTH'(STEP - 1)) != '0;
`else
   assign misaligned = 1'b0;
`endif

   // NOTE: every signal written here gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      pc_d        = pc_q;
      cnt_d       = cnt_q;
      top_d       = top_q;
      ret_err_d   = 1'b0;
      align_err_d = 1'b0;
      push        = 1'b0;
      if (!bus.stall) begin
         if (bus.ret) begin
            if (cnt_q != '0) begin
               pc_d  = ras_q[top_dec];
               cnt_d = cnt_q - CNT_W'(1);
               top_d = top_dec;
            end else begin
               // Empty stack: behave as increment; call/redirect are dropped.
               pc_d      = pc_inc;
               ret_err_d = 1'b1;
            end
         end else if (bus.call || bus.redirect) begin
            if (misaligned) begin
               pc_d        = pc_inc;
               align_err_d = 1'b1;
            end else begin
               pc_d = bus.target;
               if (bus.call) begin
                  // When full, the write at top_q overwrites the oldest entry.
                  push  = 1'b1;
                  top_d = top_inc;
                  if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end else begin
            pc_d = pc_inc;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= RESET_VEC;
         cnt_q       <= '0;
         top_q       <= '0;
         ret_err_q   <= 1'b0;
         align_err_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         cnt_q       <= cnt_d;
         top_q       <= top_d;
         ret_err_q   <= ret_err_d;
         align_err_q <= align_err_d;
      end
   end

   // NOTE: stack storage has no reset; the count and pointer alone define
   // which entries are valid, so clearing the array would only cost logic.
   always_ff @(posedge clk) begin
      if (!reset && push) ras_q[top_q] <= pc_inc;
   end

   assign bus.pc        = pc_q;
   assign bus.ras_count = cnt_q;
   assign bus.ret_err   = ret_err_q;
   assign bus.align_err = align_err_q;
endmodule
